arb_rr4_gea1: RTL



---
 rtl/arb_rr4_gea1_pkg.sv | 22 ++
 rtl/arb_rr4_gea1_pick.sv | 53 +++++
 rtl/arb_rr4_gea1.sv | 120 ++++++++++++
 3 files changed

// File: rtl/arb_rr4_gea1_pkg.sv
// ---------------------------------------------------------------------------
// arb_rr4_gea1_pkg
//   Shared definitions for the round-robin arbiter that owns the shared
//   generic-cell datapath segment.
//   - state_e     : arbiter FSM encoding (IDLE / GRANT)
//   - *_DEFAULT   : default sizing derived from a four-requester build
// ---------------------------------------------------------------------------
package arb_rr4_gea1_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Default build: four requesters, so the owner index needs two bits.
  localparam int NREQ_DEFAULT     = 4;
  localparam int IDW_DEFAULT      = 2;
  localparam int MAX_HOLD_DEFAULT = 16;
  // Hold counter must be able to represent MAX_HOLD-1 and still saturate.
  localparam int CW_DEFAULT       = 5;

endpackage : arb_rr4_gea1_pkg

// File: rtl/arb_rr4_gea1_pick.sv
// ---------------------------------------------------------------------------
// rr_pick_gea1
//   Combinational rotate-mask-priority picker. Returns the first set request
//   bit at or above ptr_i, wrapping to the lowest set bit when nothing at or
//   above the pointer is requesting.
//   Ports:
//     req_i     [NREQ-1:0] request vector
//     ptr_i     [IDW-1:0]  index where the search starts
//     pick_o    [NREQ-1:0] one-hot winner (zero when no request)
//     pick_id_o [IDW-1:0]  binary index of the winner
//     any_o                any request present
// ---------------------------------------------------------------------------
module rr_pick_gea1
  import arb_rr4_gea1_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int IDW  = IDW_DEFAULT
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] pick_o,
  output logic [IDW-1:0]  pick_id_o,
  output logic            any_o
);

  logic [NREQ-1:0] mask;
  logic [NREQ-1:0] hi_req;
  logic [NREQ-1:0] cand;

  always_comb begin
    mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      mask[i] = (i >= int'(ptr_i));
    end
    // Requests at or above the pointer take priority; otherwise wrap around.
    hi_req = req_i & mask;
    cand   = (hi_req != '0) ? hi_req : req_i;

    // Scan downward so the lowest set bit of cand is the last one written.
    pick_o    = '0;
    pick_id_o = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        pick_o    = '0;
        pick_o[i] = 1'b1;
        pick_id_o = IDW'(i);
      end
    end

    any_o = |req_i;
  end

endmodule : rr_pick_gea1

// File: rtl/arb_rr4_gea1.sv
// ---------------------------------------------------------------------------
// arb_rr4_gea1
//   Round-robin arbiter sharing one generic-cell datapath segment between
//   NREQ requesters. A grant is held while its owner keeps requesting; when
//   MAX_HOLD is non-zero and someone else is waiting, the grant is revoked
//   after MAX_HOLD grant cycles. Every change of owner passes through IDLE,
//   so there is always at least one cycle with no grant between owners.
//   Ports:
//     clk      clock, rising edge
//     rst_n    synchronous reset, active low
//     req      [NREQ-1:0] level-sensitive request vector
//     gnt      [NREQ-1:0] registered one-hot grant
//     gnt_vld  any grant bit set
//     gnt_id   [IDW-1:0]  current owner; keeps the last owner while idle
//     busy     arbiter is in GRANT
// ---------------------------------------------------------------------------
module arb_rr4_gea1
  import arb_rr4_gea1_pkg::*;
#(
  parameter int NREQ     = NREQ_DEFAULT,
  parameter int IDW      = IDW_DEFAULT,
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT,
  parameter int CW       = CW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            gnt_vld,
  output logic [IDW-1:0]  gnt_id,
  output logic            busy
);

  // Hold-counter value on which a waiting requester forces rotation.
  localparam int              HOLD_LAST_I = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [CW-1:0]   HOLD_LAST   = HOLD_LAST_I[CW-1:0];
  localparam logic [IDW-1:0]  LAST_ID     = IDW'(NREQ - 1);

  state_e          state_q;
  logic [NREQ-1:0] gnt_q;
  logic            gnt_vld_q;
  logic [IDW-1:0]  gnt_id_q;
  logic            busy_q;
  logic [IDW-1:0]  ptr_q;
  logic [CW-1:0]   hold_cnt_q;
  logic [CW-1:0]   hold_cnt_d;
  logic [IDW-1:0]  ptr_d;

  logic [NREQ-1:0] pick;
  logic [IDW-1:0]  pick_id;
  logic            pick_any;

  logic            owner_req;
  logic            others_req;
  logic            force_rot;
  logic            revoke;

  rr_pick_gea1 #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .pick_o    (pick),
    .pick_id_o (pick_id),
    .any_o     (pick_any)
  );

  always_comb begin
    owner_req  = req[gnt_id_q];
    // gnt_q is one-hot on the owner while in GRANT, so masking it out
    // leaves exactly the competing requesters.
    others_req = |(req & ~gnt_q);
    force_rot  = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST) &&
                 owner_req && others_req;
    // Release and forced rotation share one next state.
    revoke     = !owner_req || force_rot;

    hold_cnt_d = (hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + CW'(1);
    ptr_d      = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + IDW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      gnt_vld_q  <= 1'b0;
      gnt_id_q   <= '0;
      busy_q     <= 1'b0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
    end else if (state_q == ST_IDLE) begin
      if (pick_any) begin
        state_q    <= ST_GRANT;
        gnt_q      <= pick;
        gnt_vld_q  <= 1'b1;
        gnt_id_q   <= pick_id;
        busy_q     <= 1'b1;
        hold_cnt_q <= '0;
      end
    end else begin
      if (revoke) begin
        // gnt_id_q is deliberately kept so it still names the last owner.
        state_q   <= ST_IDLE;
        gnt_q     <= '0;
        gnt_vld_q <= 1'b0;
        busy_q    <= 1'b0;
        ptr_q     <= ptr_d;
      end else begin
        hold_cnt_q <= hold_cnt_d;
      end
    end
  end

  assign gnt     = gnt_q;
  assign gnt_vld = gnt_vld_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = busy_q;

endmodule : arb_rr4_gea1
